// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO unit: pipeline op codes, FSM states and the default width.
package hilo_pkg;

    localparam int HILO_DATA_W = 32;

    localparam logic [2:0] HILO_MULT  = 3'd0;
    localparam logic [2:0] HILO_MULTU = 3'd1;
    localparam logic [2:0] HILO_MFHI  = 3'd2;
    localparam logic [2:0] HILO_MFLO  = 3'd3;
    localparam logic [2:0] HILO_MTHI  = 3'd4;
    localparam logic [2:0] HILO_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_sign_fix.sv
// Sign handling around the unsigned multiplier: operand magnitudes on the way in,
// conditional two's-complement negate of the full product on the way out.
module hilo_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic                signed_i,
    input  logic [2*DATA_W-1:0] raw_i,
    input  logic                neg_i,
    output logic [DATA_W-1:0]   abs_a_o,
    output logic [DATA_W-1:0]   abs_b_o,
    output logic [2*DATA_W-1:0] fixed_o
);

    // The most negative value maps onto itself, which read as unsigned is its magnitude.
    assign abs_a_o = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
    assign abs_b_o = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;
    assign fixed_o = neg_i ? -raw_i : raw_i;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: accepts HI/LO ops from the pipeline, drives the iterative
// multiplier through its go/hold handshake and writes the sign-corrected product.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [2:0]          op_code,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    output logic                stall,
    output logic [DATA_W-1:0]   rd_val,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   mul_op1,
    output logic [DATA_W-1:0]   mul_op2,
    output logic                mul_go,
    input  logic [2*DATA_W-1:0] mul_res,
    input  logic                mul_hold,
    output logic [1:0]          state_o
);

    // Handshake: the multiplier owns the product while mul_go is high; the product is
    // valid in the cycle where mul_go & ~mul_hold, and mul_go drops at that same edge.

    hilo_state_e         state_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   op1_q, op2_q;
    logic [2*DATA_W-1:0] raw_q;
    logic                neg_q;
    logic                mul_go_q;

    logic                idle;
    logic                is_mult;
    logic [DATA_W-1:0]   abs_rs, abs_rt;
    logic [2*DATA_W-1:0] fixed;

    assign idle    = (state_q == ST_IDLE);
    assign is_mult = (op_code == HILO_MULT);

    hilo_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .a_i      (rs_val),
        .b_i      (rt_val),
        .signed_i (is_mult),
        .raw_i    (raw_q),
        .neg_i    (neg_q),
        .abs_a_o  (abs_rs),
        .abs_b_o  (abs_rt),
        .fixed_o  (fixed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            raw_q    <= '0;
            neg_q    <= 1'b0;
            mul_go_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            HILO_MULT, HILO_MULTU: begin
                                op1_q    <= abs_rs;
                                op2_q    <= abs_rt;
                                neg_q    <= is_mult & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                                mul_go_q <= 1'b1;
                                state_q  <= ST_MUL;
                            end
                            HILO_MTHI: hi_q <= rs_val;
                            HILO_MTLO: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!mul_hold) begin
                        raw_q    <= mul_res;
                        mul_go_q <= 1'b0;
                        state_q  <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    {hi_q, lo_q} <= fixed;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall    = op_valid & ~idle;
    assign rd_valid = op_valid & idle & ((op_code == HILO_MFHI) | (op_code == HILO_MFLO));
    assign rd_val   = (op_code == HILO_MFHI) ? hi_q : lo_q;
    assign mul_op1  = op1_q;
    assign mul_op2  = op2_q;
    assign mul_go   = mul_go_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed steps from the test plan plus randomized multiplies,
// checked against a 64-bit arithmetic reference and a spec-derived latency formula.
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic [2:0]     op_code;
    logic [W-1:0]   rs_val, rt_val;
    logic           stall;
    logic [W-1:0]   rd_val;
    logic           rd_valid;
    logic [W-1:0]   mul_op1, mul_op2;
    logic           mul_go;
    logic [2*W-1:0] mul_res;
    logic           mul_hold;
    logic [1:0]     state_o;

    always #5 clk = ~clk;

    hilo_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_code  (op_code),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall    (stall),
        .rd_val   (rd_val),
        .rd_valid (rd_valid),
        .mul_op1  (mul_op1),
        .mul_op2  (mul_op2),
        .mul_go   (mul_go),
        .mul_res  (mul_res),
        .mul_hold (mul_hold),
        .state_o  (state_o)
    );

    int tests = 0;
    int fails = 0;

    function automatic int bitlen(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic int mul_iters(input logic [W-1:0] mag);
        int n = bitlen(mag);
        return (n > 1) ? n - 1 : 0;
    endfunction

    // Iterative multiplier stand-in: one setup cycle, then one cycle per extra bit of op1.
    logic m_active;
    int   m_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (!m_active && mul_go) begin
            m_active <= 1'b1;
            m_cnt    <= mul_iters(mul_op1);
        end else if (m_active) begin
            if (m_cnt == 0) m_active <= 1'b0;
            else            m_cnt    <= m_cnt - 1;
        end
    end
    assign mul_hold = mul_go & (~m_active | (m_cnt != 0));
    assign mul_res  = (m_active && m_cnt == 0) ? ({32'b0, mul_op1} * {32'b0, mul_op2})
                                               : 64'hDEAD_BEEF_DEAD_BEEF;

    // Handshake monitors
    logic prev_fire;
    int   go_after_fire = 0;
    int   go_state_err  = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_fire <= 1'b0;
        end else begin
            if (prev_fire && mul_go) go_after_fire <= go_after_fire + 1;
            if (mul_go !== (state_o == ST_MUL)) go_state_err <= go_state_err + 1;
            prev_fire <= mul_go & ~mul_hold;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input bit sgn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int ref_latency(input bit sgn, input logic [W-1:0] a);
        logic [W-1:0] m;
        m = (sgn && a[W-1]) ? -a : a;
        return 4 + mul_iters(m);
    endfunction

    int rd_during_stall = 0;

    // Presents one op in the cycle after the previous one; returns stalled cycles and read data.
    task automatic issue(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waits, output logic [W-1:0] rd, output logic rdv);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        rs_val   = a;
        rt_val   = b;
        waits    = 0;
        #1;
        while (stall && waits < 100) begin
            if (rd_valid) rd_during_stall++;
            @(negedge clk);
            #1;
            waits++;
        end
        rd  = rd_val;
        rdv = rd_valid;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    logic [W-1:0] m_hi, m_lo;
    int           waits;
    logic [W-1:0] rd;
    logic         rdv;

    // MULT/MULTU followed immediately by MFHI then MFLO, all checked against the model.
    task automatic mul_and_read(input string tag, input bit sgn, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        logic [63:0] p;
        issue(sgn ? HILO_MULT : HILO_MULTU, a, b, waits, rd, rdv);
        check({tag, " accept"}, 64'(waits), 64'd0);
        p = ref_prod(sgn, a, b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        issue(HILO_MFHI, 32'h0, 32'h0, waits, rd, rdv);
        check({tag, " mfhi stall"}, 64'(waits), 64'(ref_latency(sgn, a) - 1));
        check({tag, " hi"}, {32'b0, rd}, {32'b0, m_hi});
        check({tag, " rd_valid"}, {63'b0, rdv}, 64'd1);
        issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
        check({tag, " lo"}, {32'b0, rd}, {32'b0, m_lo});
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        m_hi     = '0;
        m_lo     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {62'b0, state_o}, {62'b0, ST_IDLE});
        check("reset mul_go", {63'b0, mul_go}, 64'd0);
        check("reset ops", {mul_op1, mul_op2}, 64'd0);
        check("reset stall", {62'b0, stall, rd_valid}, 64'd0);
        rst = 1'b0;

        issue(HILO_MFHI, 32'h0, 32'h0, waits, rd, rdv);
        check("reset hi", {32'b0, rd}, 64'd0);
        issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
        check("reset lo", {32'b0, rd}, 64'd0);

        mul_and_read("multu max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max hi const", {32'b0, m_hi}, 64'hFFFF_FFFE);
        mul_and_read("mult -3*5", 1'b1, 32'hFFFF_FFFD, 32'd5);
        check("mult -3*5 lo const", {32'b0, m_lo}, 64'hFFFF_FFF1);
        mul_and_read("mult minint", 1'b1, 32'h8000_0000, 32'h8000_0000);
        mul_and_read("mult 1*7", 1'b1, 32'd1, 32'd7);
        check("mult 1*7 lo const", {32'b0, m_lo}, 64'd7);

        // Back-to-back MULTs: the second must wait for the first to retire.
        issue(HILO_MULT, 32'd3, 32'd3, waits, rd, rdv);
        check("b2b first accept", 64'(waits), 64'd0);
        issue(HILO_MULT, 32'd4, 32'd4, waits, rd, rdv);
        check("b2b second stall", 64'(waits), 64'(ref_latency(1'b1, 32'd3) - 1));
        m_hi = 32'd0;
        m_lo = 32'd16;
        issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
        check("b2b lo", {32'b0, rd}, 64'd16);

        issue(HILO_MTHI, 32'h1234_5678, 32'h0, waits, rd, rdv);
        check("mthi accept", 64'(waits), 64'd0);
        issue(HILO_MTLO, 32'h9ABC_DEF0, 32'h0, waits, rd, rdv);
        issue(HILO_MFHI, 32'h0, 32'h0, waits, rd, rdv);
        check("mthi readback", {32'b0, rd}, 64'h1234_5678);
        issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
        check("mtlo readback", {32'b0, rd}, 64'h9ABC_DEF0);

        issue(3'd6, 32'hFFFF_FFFF, 32'h1, waits, rd, rdv);
        check("code6 no stall", {32'(waits), 31'b0, rdv}, 64'd0);
        issue(HILO_MFHI, 32'h0, 32'h0, waits, rd, rdv);
        check("code6 hi kept", {32'b0, rd}, 64'h1234_5678);

        // Reset in the middle of a long multiply.
        issue(HILO_MULT, 32'h7FFF_FFFF, 32'd5, waits, rd, rdv);
        @(negedge clk);
        check("pre-rst busy", {62'b0, state_o}, {62'b0, ST_MUL});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst state", {62'b0, state_o}, {62'b0, ST_IDLE});
        check("rst mul_go", {63'b0, mul_go}, 64'd0);
        issue(HILO_MFHI, 32'h0, 32'h0, waits, rd, rdv);
        check("rst hi", {32'(waits), rd}, 64'd0);
        issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
        check("rst lo", {32'b0, rd}, 64'd0);
        mul_and_read("post-rst 2*3", 1'b1, 32'd2, 32'd3);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] a, b;
            bit           sgn;
            a   = $urandom() >> $urandom_range(0, 31);
            b   = $urandom();
            if ($urandom_range(0, 1) == 1) a = -a;
            sgn = bit'($urandom_range(0, 1));
            mul_and_read($sformatf("rand%0d", i), sgn, a, b);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom();
                issue(HILO_MTLO, a, 32'h0, waits, rd, rdv);
                issue(HILO_MFLO, 32'h0, 32'h0, waits, rd, rdv);
                check($sformatf("rand%0d mtlo", i), {32'b0, rd}, {32'b0, a});
            end
        end

        repeat (2) @(negedge clk);
        check("go after product", 64'(go_after_fire), 64'd0);
        check("go vs state MUL", 64'(go_state_err), 64'd0);
        check("rd_valid while stalled", 64'(rd_during_stall), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
